// File: rtl/stage_timer_bank.sv
// stage_timer_bank
// ----------------
// Multi-stage latency instrumentation. Each of NUM_STAGES stages owns a
// cycle counter with a three-state FSM (IDLE / RUN / HELD). A commit pulse
// snapshots every stage count plus saturation/incomplete flags into one output
// record and re-arms all stages. A clear pulse re-arms without a snapshot.
//
// Optional feature macro: STAGE_TIMER_BANK_TOTAL_EN
//   When defined, adds out_total = sum of all snapshotted stage counts,
//   registered together with the record.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start[i], stop[i]   per-stage begin / end pulses
//   commit              snapshot all stages into the record and re-arm
//   clear               abort the transaction, re-arm without a snapshot
//   active[i]           stage i is currently counting (RUN)
//   out_valid/out_ready record handshake. A record transfers on a cycle where
//                       out_valid && out_ready. The fields stay stable while
//                       out_valid is high and out_ready is low. out_ready is
//                       ignored while out_valid is low.
//   out_cycles          stage i count at bits [i*WIDTH +: WIDTH]
//   out_sat[i]          stage i count reached its maximum
//   out_incomplete[i]   stage i was still running at commit
//   drop_count          records lost to back-pressure, saturating
//   out_total           (feature only) sum of the snapshotted counts

module stage_timer_bank #(
    parameter int NUM_STAGES = 4,
    parameter int WIDTH      = 32,
    parameter int DROP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_STAGES-1:0]         start,
    input  logic [NUM_STAGES-1:0]         stop,
    input  logic                          commit,
    input  logic                          clear,
    output logic [NUM_STAGES-1:0]         active,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_STAGES*WIDTH-1:0]   out_cycles,
    output logic [NUM_STAGES-1:0]         out_sat,
    output logic [NUM_STAGES-1:0]         out_incomplete,
    output logic [DROP_WIDTH-1:0]         drop_count
`ifdef STAGE_TIMER_BANK_TOTAL_EN
    ,
    output logic [WIDTH+$clog2(NUM_STAGES+1)-1:0] out_total
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    localparam logic [WIDTH-1:0]      CNT_MAX  = '1;
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    // Per-stage state
    logic [1:0]       state_q [NUM_STAGES];
    logic [1:0]       state_d [NUM_STAGES];
    logic [WIDTH-1:0] cnt_q   [NUM_STAGES];
    logic [WIDTH-1:0] cnt_d   [NUM_STAGES];
    logic [NUM_STAGES-1:0] sat_q, sat_d;

    // Output record
    logic                        out_valid_q, out_valid_d;
    logic [NUM_STAGES*WIDTH-1:0] out_cycles_q, out_cycles_d;
    logic [NUM_STAGES-1:0]       out_sat_q, out_sat_d;
    logic [NUM_STAGES-1:0]       out_incomplete_q, out_incomplete_d;
    logic [DROP_WIDTH-1:0]       drop_count_q, drop_count_d;

    logic rearm;
    logic load;
    logic drop;

    // clear outranks commit, so a commit coinciding with clear does nothing
    // beyond the re-arm that clear already performs.
    assign rearm = clear | commit;
    assign load  = commit & ~clear & (~out_valid_q | out_ready);
    assign drop  = commit & ~clear & ~load;

    // Stage FSMs
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            sat_d[i]   = sat_q[i];
            if (rearm) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                sat_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (start[i]) begin
                            // The start cycle itself counts as one.
                            cnt_d[i]   = WIDTH'(1);
                            state_d[i] = stop[i] ? ST_HELD : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (stop[i]) begin
                            state_d[i] = ST_HELD;
                        end else if (cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + WIDTH'(1);
                            if (cnt_q[i] + WIDTH'(1) == CNT_MAX) begin
                                sat_d[i] = 1'b1;
                            end
                        end
                    end
                    ST_HELD: ;
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                        sat_d[i]   = 1'b0;
                    end
                endcase
            end
        end
    end

    // Output record and drop accounting
    always_comb begin
        out_valid_d      = out_valid_q;
        out_cycles_d     = out_cycles_q;
        out_sat_d        = out_sat_q;
        out_incomplete_d = out_incomplete_q;
        drop_count_d     = drop_count_q;
        if (load) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
                out_cycles_d[i*WIDTH +: WIDTH] = cnt_q[i];
                out_incomplete_d[i]            = (state_q[i] == ST_RUN);
            end
            out_sat_d = sat_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (drop && drop_count_q != DROP_MAX) begin
            drop_count_d = drop_count_q + DROP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            sat_q            <= '0;
            out_valid_q      <= 1'b0;
            out_cycles_q     <= '0;
            out_sat_q        <= '0;
            out_incomplete_q <= '0;
            drop_count_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sat_q            <= sat_d;
            out_valid_q      <= out_valid_d;
            out_cycles_q     <= out_cycles_d;
            out_sat_q        <= out_sat_d;
            out_incomplete_q <= out_incomplete_d;
            drop_count_q     <= drop_count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            active[i] = (state_q[i] == ST_RUN);
        end
    end

    assign out_valid      = out_valid_q;
    assign out_cycles     = out_cycles_q;
    assign out_sat        = out_sat_q;
    assign out_incomplete = out_incomplete_q;
    assign drop_count     = drop_count_q;

`ifdef STAGE_TIMER_BANK_TOTAL_EN
    localparam int TW = WIDTH + $clog2(NUM_STAGES + 1);

    logic [TW-1:0] total_q, total_d;

    // The total follows the record load only; drops leave it untouched.
    always_comb begin
        total_d = total_q;
        if (load) begin
            total_d = '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                total_d = total_d + TW'(cnt_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign out_total = total_q;
`endif

endmodule

// File: tb/tb_stage_timer_bank.sv
// Bench for stage_timer_bank: reference model of elapsed stage time plus
// directed scenarios with literal expectations and a randomized phase.

module tb_stage_timer_bank;

    localparam int NS = 4;
    localparam int W  = 8;
    localparam int DW = 4;
    localparam longint CMAX = (64'd1 << W) - 1;
    localparam int     DMAX = (1 << DW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NS-1:0]        start = '0;
    logic [NS-1:0]        stop = '0;
    logic                 commit = 1'b0;
    logic                 clear = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NS-1:0]        active;
    logic                 out_valid;
    logic [NS*W-1:0]      out_cycles;
    logic [NS-1:0]        out_sat;
    logic [NS-1:0]        out_incomplete;
    logic [DW-1:0]        drop_count;
`ifdef STAGE_TIMER_BANK_TOTAL_EN
    logic [W+$clog2(NS+1)-1:0] out_total;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stage_timer_bank #(.NUM_STAGES(NS), .WIDTH(W), .DROP_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .commit         (commit),
        .clear          (clear),
        .active         (active),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_cycles     (out_cycles),
        .out_sat        (out_sat),
        .out_incomplete (out_incomplete),
        .drop_count     (drop_count)
`ifdef STAGE_TIMER_BANK_TOTAL_EN
        ,
        .out_total      (out_total)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: each stage tracks the true number of counted cycles;
    // the record clamps it to the counter range and flags saturation.
    bit     m_run   [NS];
    bit     m_held  [NS];
    longint m_cnt   [NS];
    bit     m_valid;
    longint m_cyc   [NS];
    bit [NS-1:0] m_sat, m_inc;
    int     m_drops;
    longint m_total;

    always @(posedge clk or negedge rst_n) begin
        bit accept, load;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                m_run[i] = 0; m_held[i] = 0; m_cnt[i] = 0; m_cyc[i] = 0;
            end
            m_valid = 0; m_sat = '0; m_inc = '0; m_drops = 0; m_total = 0;
        end else begin
            accept = m_valid && out_ready;
            load   = commit && !clear && (!m_valid || out_ready);
            if (load) begin
                m_valid = 1;
                m_total = 0;
                for (int i = 0; i < NS; i++) begin
                    m_cyc[i] = (m_cnt[i] > CMAX) ? CMAX : m_cnt[i];
                    m_sat[i] = (m_cnt[i] >= CMAX);
                    m_inc[i] = m_run[i];
                    m_total += m_cyc[i];
                end
            end else begin
                if (accept) m_valid = 0;
                if (commit && !clear && m_drops < DMAX) m_drops++;
            end
            for (int i = 0; i < NS; i++) begin
                if (clear || commit) begin
                    m_run[i] = 0; m_held[i] = 0; m_cnt[i] = 0;
                end else if (!m_run[i] && !m_held[i]) begin
                    if (start[i]) begin
                        m_cnt[i] = 1;
                        if (stop[i]) m_held[i] = 1;
                        else         m_run[i]  = 1;
                    end
                end else if (m_run[i]) begin
                    if (stop[i]) begin
                        m_run[i] = 0; m_held[i] = 1;
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    // Scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        logic [NS*W-1:0] e_cyc;
        logic [NS-1:0]   e_act;
        for (int i = 0; i < NS; i++) begin
            e_cyc[i*W +: W] = W'(m_cyc[i]);
            e_act[i]        = m_run[i];
        end
        check("active", 64'(active), 64'(e_act));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_cycles", 64'(out_cycles), 64'(e_cyc));
        check("out_sat", 64'(out_sat), 64'(m_sat));
        check("out_incomplete", 64'(out_incomplete), 64'(m_inc));
        check("drop_count", 64'(drop_count), 64'(m_drops));
`ifdef STAGE_TIMER_BANK_TOTAL_EN
        check("out_total", 64'(out_total), 64'(m_total));
`endif
    end

    // Driver: apply one cycle of inputs, return 1 time unit after the edge
    task automatic step(input logic [NS-1:0] s, input logic [NS-1:0] p,
                        input logic cm, input logic cl, input logic rd);
        start = s; stop = p; commit = cm; clear = cl; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0, rd);
    endtask

    initial begin
        #12;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_cycles", 64'(out_cycles), 64'd0);
        check("reset_drop", 64'(drop_count), 64'd0);
        #10 rst_n = 1'b1;

        // Basic: stage0 t0..t5, stage1 t5..t7, commit t8
        step(4'b0001, 4'b0000, 0, 0, 1);
        idle(4, 1);
        step(4'b0010, 4'b0001, 0, 0, 1);
        idle(1, 1);
        step(4'b0000, 4'b0010, 0, 0, 1);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_cycles", 64'(out_cycles), 64'h0000_0205);
        check("basic_inc", 64'(out_incomplete), 64'd0);
        check("basic_sat", 64'(out_sat), 64'd0);
`ifdef STAGE_TIMER_BANK_TOTAL_EN
        check("basic_total", 64'(out_total), 64'd7);
`endif

        // Edge cases: single-cycle stage, unfinished stage, ignored events
        step(4'b0100, 4'b0100, 0, 0, 1);
        step(4'b1000, 4'b0000, 0, 0, 1);
        step(4'b0100, 4'b0001, 0, 0, 1);
        idle(1, 1);
        check("edge_active", 64'(active), 64'b1000);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("edge_cycles", 64'(out_cycles), 64'h0301_0000);
        check("edge_inc", 64'(out_incomplete), 64'b1000);
        check("edge_active_rearm", 64'(active), 64'd0);

        // Saturation at 2^W-1, then sticky flag cleared by the re-arm
        step(4'b0001, 4'b0000, 0, 0, 1);
        idle(300, 1);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("sat_cycles", 64'(out_cycles), 64'h0000_00ff);
        check("sat_flag", 64'(out_sat), 64'b0001);
        step(4'b0001, 4'b0000, 0, 0, 1);
        idle(2, 1);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("sat_rearm_flag", 64'(out_sat), 64'd0);
        check("sat_rearm_cycles", 64'(out_cycles), 64'h0000_0003);

        // Back-pressure: held record, drop, then accept-and-load same cycle
        idle(1, 1);
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        step(4'b0001, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 0);
        check("bp_held_cycles", 64'(out_cycles), 64'h0000_0200);
        check("bp_drop", 64'(drop_count), 64'd1);
        check("bp_rearm", 64'(active), 64'd0);
        step(4'b0100, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("bp_reload_valid", 64'(out_valid), 64'd1);
        check("bp_reload_cycles", 64'(out_cycles), 64'h0001_0000);
        check("bp_reload_drop", 64'(drop_count), 64'd1);

        // clear beats commit; start ignored while RUN and while HELD
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 1, 0);
        check("clr_active", 64'(active), 64'd0);
        check("clr_drop", 64'(drop_count), 64'd1);
        check("clr_cycles", 64'(out_cycles), 64'h0001_0000);
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0010, 0, 0, 0);
        step(4'b0010, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 1, 0, 1);
        check("rerun_cycles", 64'(out_cycles), 64'h0000_0200);

        // Reset mid-RUN with a pending record
        step(4'b0001, 4'b0000, 0, 0, 0);
        step(4'b0000, 4'b0000, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_cycles", 64'(out_cycles), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic; alternate short-stage and long-stage windows
        for (int k = 0; k < 4000; k++) begin
            logic [NS-1:0] s, p;
            logic cm, cl, rd;
            bit lng;
            lng = ((k / 400) % 2) == 1;
            for (int i = 0; i < NS; i++) begin
                s[i] = ($urandom_range(0, 7) == 0);
                p[i] = lng ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 7) == 0);
            end
            cm = lng ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 15) == 0);
            cl = lng ? 1'b0 : ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 1) == 1);
            step(s, p, cm, cl, rd);
        end

        idle(2, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
